// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the control unit.
// State encoding, opcodes, ALU selects, default field widths.
package cu_pkg;

  localparam int IW   = 16;
  localparam int DAW  = 8;
  localparam int RAW  = 4;
  localparam int ALUW = 3;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;

endpackage

// File: rtl/cu_decode.sv
// cu_decode: pure field extraction from the 16-bit IR.
// No state; every field is a fixed slice of the instruction.
module cu_decode (
  input  logic [cu_pkg::IW-1:0]  ir,
  output logic [3:0]             opcode,
  output logic [cu_pkg::RAW-1:0] ra,
  output logic [cu_pkg::RAW-1:0] rb,
  output logic [cu_pkg::RAW-1:0] rd,
  output logic [cu_pkg::DAW-1:0] ld_addr,
  output logic [cu_pkg::DAW-1:0] st_addr
);

  assign opcode  = ir[15:12];
  assign ra      = ir[11:8];
  assign rb      = ir[7:4];
  assign rd      = ir[3:0];
  assign ld_addr = ir[11:4];
  assign st_addr = ir[7:0];

endmodule

// File: rtl/control_fsm.sv
// control_fsm: Moore instruction sequencer for the control unit.
// Optional macro CU_ILLEGAL_TRAP_EN: undefined opcodes halt and raise Illegal.
module control_fsm #(
  parameter int IW   = cu_pkg::IW,
  parameter int DAW  = cu_pkg::DAW,
  parameter int RAW  = cu_pkg::RAW,
  parameter int ALUW = cu_pkg::ALUW
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic [IW-1:0]   IR,
  output logic            PC_Clr,
  output logic            PC_Up,
  output logic            IR_ld,
  output logic [DAW-1:0]  D_Addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [RAW-1:0]  RF_W_addr,
  output logic            RF_W_en,
  output logic [RAW-1:0]  RF_Ra_addr,
  output logic [RAW-1:0]  RF_Rb_addr,
  output logic [ALUW-1:0] ALU_s0,
`ifdef CU_ILLEGAL_TRAP_EN
  output logic            Illegal,
`endif
  output logic [3:0]      State
);

  import cu_pkg::*;

  state_t state;
  state_t next;

  logic [3:0]     opcode;
  logic [RAW-1:0] ra;
  logic [RAW-1:0] rb;
  logic [RAW-1:0] rd;
  logic [DAW-1:0] ld_addr;
  logic [DAW-1:0] st_addr;

`ifdef CU_ILLEGAL_TRAP_EN
  localparam state_t UNDEF_NEXT = S_HALT;
`else
  localparam state_t UNDEF_NEXT = S_NOOP;
`endif

  cu_decode u_dec (
    .ir      (IR),
    .opcode  (opcode),
    .ra      (ra),
    .rb      (rb),
    .rd      (rd),
    .ld_addr (ld_addr),
    .st_addr (st_addr)
  );

  // State register; reset forces Init at once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_INIT;
    else          state <= next;
  end

  // Next-state: fixed sequence, branching only in Decode.
  always_comb begin
    next = state;
    unique case (state)
      S_INIT:   next = S_FETCH;
      S_FETCH:  next = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          opcode == OP_NOOP:  next = S_NOOP;
          opcode == OP_STORE: next = S_STORE;
          opcode == OP_LOAD:  next = S_LOADA;
          opcode == OP_ADD:   next = S_ADD;
          opcode == OP_SUB:   next = S_SUB;
          opcode == OP_HALT:  next = S_HALT;
          default:            next = UNDEF_NEXT;
        endcase
      end
      S_LOADA:  next = S_LOADB;
      S_NOOP,
      S_LOADB,
      S_STORE,
      S_ADD,
      S_SUB:    next = S_FETCH;
      S_HALT:   next = S_HALT;
      default:  next = S_INIT;
    endcase
  end

  // Control word per state; all fields idle unless listed.
  always_comb begin
    PC_Clr     = 1'b0;
    PC_Up      = 1'b0;
    IR_ld      = 1'b0;
    D_Addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = '0;
    unique case (state)
      S_INIT:  PC_Clr = 1'b1;
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_Up = 1'b1;
      end
      S_LOADA: begin
        D_Addr    = ld_addr;
        RF_s      = 1'b1;
        RF_W_addr = rd;
      end
      S_LOADB: begin
        D_Addr    = ld_addr;
        RF_s      = 1'b1;
        RF_W_addr = rd;
        RF_W_en   = 1'b1;
      end
      S_STORE: begin
        D_Addr     = st_addr;
        RF_Ra_addr = ra;
        D_wr       = 1'b1;
      end
      S_ADD: begin
        RF_Ra_addr = ra;
        RF_Rb_addr = rb;
        RF_W_addr  = rd;
        ALU_s0     = ALU_ADD;
        RF_W_en    = 1'b1;
      end
      S_SUB: begin
        RF_Ra_addr = ra;
        RF_Rb_addr = rb;
        RF_W_addr  = rd;
        ALU_s0     = ALU_SUB;
        RF_W_en    = 1'b1;
      end
      default: ;
    endcase
  end

  assign State = state;

`ifdef CU_ILLEGAL_TRAP_EN
  logic ill_q;

  // Sticky trap flag, set as Decode sends an undefined opcode to Halt.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      ill_q <= 1'b0;
    else if (state == S_DECODE && opcode > OP_HALT)
      ill_q <= 1'b1;
  end

  assign Illegal = ill_q;
`endif

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
Instruction-sequencing state machine for the processor control unit, directly downstream of the PC/IR/ROM fetch path.
- Consumes the 16-bit instruction held in IR.
- Drives the fetch controls (PC_Clr, PC_Up, IR_ld) back to that path.
- Decodes the instruction and issues per-state control words to the data memory, register file and ALU.
- Moore machine; one instruction completes per 3–4 cycles.

Parameters:
IW, 16, instruction width
DAW, 8, data memory address width
RAW, 4, register file address width
ALUW, 3, ALU select width

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
IR  in  IW  instruction from the IR (inst_out of the fetch path)
PC_Clr  out  1  clear program counter
PC_Up  out  1  increment program counter
IR_ld  out  1  load IR from ROM output
D_Addr  out  DAW  data memory address
D_wr  out  1  data memory write enable
RF_s  out  1  register write mux: 1 = memory data, 0 = ALU result
RF_W_addr  out  RAW  register write address
RF_W_en  out  1  register write enable
RF_Ra_addr  out  RAW  register read port A address
RF_Rb_addr  out  RAW  register read port B address
ALU_s0  out  ALUW  ALU function select
State  out  4  current state encoding (debug)

Behaviour:
- Clocking and reset: one clock, Clk. Reset_n is asynchronous and active-low; asserting it forces state Init immediately, mid-instruction included. Outputs are decoded combinationally from the state register only.
- Reset output values (Init): PC_Clr=1; every other control = 0; all address outputs = 0; State=0.
- Instruction formats, opcode in IR[15:12]:
  - NOOP 0000
  - STORE 0001: Ra=[11:8], addr=[7:0]
  - LOAD 0010: addr=[11:4], Rd=[3:0]
  - ADD 0011 / SUB 0100: Ra=[11:8], Rb=[7:4], Rd=[3:0]
  - HALT 0101
  - 0110–1111 undefined
- States and transitions:
  - Init(0) -> Fetch unconditionally. Output PC_Clr=1.
  - Fetch(1): IR_ld=1, PC_Up=1. -> Decode.
  - Decode(2): no controls asserted; the IR value is stable here. Opcode selects Noop/Store/LoadA/Add/Sub/Halt; an undefined opcode selects Noop.
  - Noop(3) -> Fetch.
  - LoadA(4): D_Addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0]. -> LoadB.
  - LoadB(5): same as LoadA plus RF_W_en=1. -> Fetch.
  - Store(6): D_Addr=IR[7:0], RF_Ra_addr=IR[11:8], D_wr=1. -> Fetch.
  - Add(7): RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], ALU_s0=1, RF_s=0, RF_W_en=1. -> Fetch.
  - Sub(8): as Add but ALU_s0=2. -> Fetch.
  - Halt(9): all controls 0; PC frozen. Stays in Halt until Reset_n is asserted.
- Address and ALU outputs not listed for a state are 0. ALU_s0=0 outside Add/Sub.
- Latency, counted from Fetch: NOOP/STORE/ADD/SUB take 3 cycles, LOAD takes 4. PC_Up pulses exactly once per instruction.
- PC_Up and PC_Clr are never high together.
- PC wrap-around (127->0) belongs to the PC and needs no special handling here.
- The IR input is sampled only in Decode and the execute states. Changes on IR during Fetch have no effect on the controls of the current instruction.

Optional Feature:
CU_ILLEGAL_TRAP_EN
- Defined: an undefined opcode in Decode transitions to Halt. An extra output Illegal (1 bit) goes to 1 there, stays 1 while halted, and is cleared by reset.
- Undefined: undefined opcodes execute as NOOP and no Illegal port exists.

Decomposition:
- Package cu_pkg holds:
  - state_t enum (Init..Halt, 4-bit, values as listed above)
  - opcode localparams OP_NOOP..OP_HALT
  - ALU select constants ALU_ADD=1 and ALU_SUB=2
  - the IW, DAW and RAW defaults
- One natural sub-module, cu_decode: combinational field extraction of opcode, Ra, Rb, Rd, load address and store address from IR, instantiated inside control_fsm.

Test Plan:
1. Reset_n=0 for 2 cycles, then release: PC_Clr=1 and State=0 while in reset; after release, Init -> Fetch with IR_ld=1 and PC_Up=1 for exactly one cycle.
2. IR=16'h3214 (ADD Ra=2, Rb=1, Rd=4): in Add, RF_Ra_addr=2, RF_Rb_addr=1, RF_W_addr=4, ALU_s0=1, RF_W_en=1. Back in Fetch 3 cycles after the prior Fetch.
3. IR=16'h21B3 (LOAD addr=0x1B, Rd=3): LoadA gives D_Addr=0x1B, RF_s=1, RF_W_en=0. LoadB gives RF_W_en=1 and RF_W_addr=3. Total 4 cycles.
4. IR=16'h1547 (STORE Ra=5, addr=0x47): D_wr=1, D_Addr=0x47 and RF_Ra_addr=5 for exactly one cycle.
5. IR=16'h5000 (HALT): State=9 and held for 20 cycles with PC_Up=0 and IR_ld=0. Reset_n low then high restarts at Init.
6. IR=16'hF000:
   - without the macro: State goes 2 -> 3 -> 1.
   - with CU_ILLEGAL_TRAP_EN: State goes 2 -> 9 with Illegal=1.
   - Reset_n asserted mid-LoadA in either build: State=0 in the same cycle and D_Addr=0.
